// File: rtl/stream_ring_buffer_if.sv
// Valid/ready stream bundle for the ring buffer: producer side (in_*) and consumer side (out_*).
// The buffer connects through the slave modport; the driving environment uses master.
interface stream_ring_buffer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] in_data_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] out_data_o;

    modport slave (
        input  in_valid_i,
        input  in_data_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output out_data_o
    );

    modport master (
        output in_valid_i,
        output in_data_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  out_data_o
    );
endinterface

// File: rtl/stream_ring_buffer.sv
// First-word-fall-through ring buffer with fill count, threshold flags, synchronous flush
// and optional overwrite-oldest mode with a saturating drop counter. Any LENGTH >= 1.
module stream_ring_buffer #(
    parameter int WIDTH        = 8,
    parameter int LENGTH       = 1024,
    parameter int OVERWRITABLE = 0,
    parameter int AF_THRESH    = LENGTH - 1,
    parameter int AE_THRESH    = 1,
    parameter int DROP_CNT_W   = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          flush_i,
    stream_ring_buffer_if.slave           strm,
    output logic [$clog2(LENGTH+1)-1:0]   count_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic                          almost_full_o,
    output logic                          almost_empty_o,
    output logic                          drop_o,
    output logic [DROP_CNT_W-1:0]         drop_cnt_o
);

    localparam int PTR_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int CNT_W = $clog2(LENGTH + 1);
    localparam bit OW    = (OVERWRITABLE != 0);

    typedef logic [PTR_W-1:0]      ptr_t;
    typedef logic [CNT_W-1:0]      cnt_t;
    typedef logic [DROP_CNT_W-1:0] drop_t;

    localparam ptr_t LAST_PTR = PTR_W'(LENGTH - 1);
    localparam cnt_t LEN_C    = CNT_W'(LENGTH);
    localparam cnt_t AF_C     = CNT_W'(AF_THRESH);
    localparam cnt_t AE_C     = CNT_W'(AE_THRESH);

    // Wrap by explicit compare so non-power-of-2 depths never index past the array.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    logic [WIDTH-1:0] mem [LENGTH];

    ptr_t  wr_ptr, wr_ptr_nxt;
    ptr_t  rd_ptr, rd_ptr_nxt;
    cnt_t  count, count_nxt;
    drop_t drop_cnt, drop_cnt_nxt;

    logic full, empty, in_ready, out_valid;
    logic push, pop, overwrite;

    // Flags come only from the registered count, so they never glitch on input changes.
    assign full  = (count == LEN_C);
    assign empty = (count == '0);

    assign in_ready  = !flush_i && (!full || OW || strm.out_ready_i);
    assign out_valid = !empty && !flush_i;
    assign push      = strm.in_valid_i && in_ready;
    assign pop       = out_valid && strm.out_ready_i;
    assign overwrite = OW && full && push && !pop;

    // NOTE: every variable assigned in this block gets a default first, so no path can infer a latch.
    always_comb begin
        wr_ptr_nxt   = wr_ptr;
        rd_ptr_nxt   = rd_ptr;
        count_nxt    = count;
        drop_cnt_nxt = drop_cnt;
        if (flush_i) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            count_nxt  = '0;
        end else begin
            if (push) begin
                wr_ptr_nxt = ptr_inc(wr_ptr);
            end
            // An overwrite discards the oldest entry, which moves the read side as a pop would.
            if (pop || overwrite) begin
                rd_ptr_nxt = ptr_inc(rd_ptr);
            end
            if (push && !pop && !overwrite) begin
                count_nxt = count + CNT_W'(1);
            end else if (pop && !push) begin
                count_nxt = count - CNT_W'(1);
            end
            if (overwrite && (drop_cnt != '1)) begin
                drop_cnt_nxt = drop_cnt + DROP_CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            count    <= count_nxt;
            drop_cnt <= drop_cnt_nxt;
        end
    end

    // NOTE: storage has no reset; stale entries are unreachable because count gates out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= strm.in_data_i;
        end
    end

    assign strm.in_ready_o  = in_ready;
    assign strm.out_valid_o = out_valid;
    assign strm.out_data_o  = out_valid ? mem[rd_ptr] : '0;

    assign count_o        = count;
    assign full_o         = full;
    assign empty_o        = empty;
    assign almost_full_o  = (count >= AF_C);
    assign almost_empty_o = (count <= AE_C);
    assign drop_o         = overwrite;
    assign drop_cnt_o     = drop_cnt;

endmodule

// File: tb/tb_stream_ring_buffer.sv
// Directed bench: a back-pressure instance and an overwrite instance, both LENGTH=5,
// AF_THRESH=4, AE_THRESH=1, exercised by one task per scenario.
module tb_stream_ring_buffer;

    logic clk;
    logic rstn;
    logic flush;
    logic flush_ow;

    stream_ring_buffer_if #(.WIDTH(8)) bus ();
    stream_ring_buffer_if #(.WIDTH(8)) bus_ow ();

    logic [2:0]  count, count_ow;
    logic        full, full_ow, empty, empty_ow;
    logic        af, af_ow, ae, ae_ow;
    logic        drop, drop_ow;
    logic [15:0] drop_cnt, drop_cnt_ow;

    int errors = 0;
    int checks = 0;

    stream_ring_buffer #(
        .WIDTH(8), .LENGTH(5), .OVERWRITABLE(0), .AF_THRESH(4), .AE_THRESH(1), .DROP_CNT_W(16)
    ) dut (
        .clk(clk), .rstn(rstn), .flush_i(flush), .strm(bus.slave),
        .count_o(count), .full_o(full), .empty_o(empty),
        .almost_full_o(af), .almost_empty_o(ae),
        .drop_o(drop), .drop_cnt_o(drop_cnt)
    );

    stream_ring_buffer #(
        .WIDTH(8), .LENGTH(5), .OVERWRITABLE(1), .AF_THRESH(4), .AE_THRESH(1), .DROP_CNT_W(16)
    ) dut_ow (
        .clk(clk), .rstn(rstn), .flush_i(flush_ow), .strm(bus_ow.slave),
        .count_o(count_ow), .full_o(full_ow), .empty_o(empty_ow),
        .almost_full_o(af_ow), .almost_empty_o(ae_ow),
        .drop_o(drop_ow), .drop_cnt_o(drop_cnt_ow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic fill_dut(input logic [7:0] base);
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = base + 8'(i);
        end
        @(negedge clk);
        bus.in_valid_i = 1'b0;
    endtask

    task automatic fill_ow(input logic [7:0] base);
        bus_ow.out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus_ow.in_valid_i = 1'b1;
            bus_ow.in_data_i  = base + 8'(i);
        end
        @(negedge clk);
        bus_ow.in_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready_o); end
        checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid_o); end
        checks++; if (bus.out_data_o !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", bus.out_data_o); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (ae !== 1'b1) begin errors++; $display("FAIL reset_ae: got %b want 1", ae); end
        checks++; if (af !== 1'b0) begin errors++; $display("FAIL reset_af: got %b want 0", af); end
        checks++; if (drop_ow !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b want 0", drop_ow); end
        checks++; if (drop_cnt_ow !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt_ow); end
    endtask

    task automatic test_fill();
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = 8'h11 + 8'(i);
            #1;
            checks++; if (count !== 3'(i)) begin errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i); end
            checks++; if (af !== 1'(i >= 4)) begin errors++; $display("FAIL fill_af[%0d]: got %b want %b", i, af, i >= 4); end
            checks++; if (ae !== 1'(i <= 1)) begin errors++; $display("FAIL fill_ae[%0d]: got %b want %b", i, ae, i <= 1); end
            checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL fill_in_ready[%0d]: got %b want 1", i, bus.in_ready_o); end
        end
        @(negedge clk);
        bus.in_data_i = 8'h66;
        #1;
        checks++; if (count !== 3'd5) begin errors++; $display("FAIL full_count: got %0d want 5", count); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b want 1", full); end
        checks++; if (af !== 1'b1) begin errors++; $display("FAIL full_af: got %b want 1", af); end
        checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b want 0", bus.in_ready_o); end
        checks++; if (bus.out_data_o !== 8'h11) begin errors++; $display("FAIL full_out_data: got %h want 11", bus.out_data_o); end
        @(negedge clk);
        #1;
        checks++; if (count !== 3'd5) begin errors++; $display("FAIL held_count: got %0d want 5", count); end
        checks++; if (bus.out_data_o !== 8'h11) begin errors++; $display("FAIL held_out_data: got %h want 11", bus.out_data_o); end
        bus.in_valid_i = 1'b0;
    endtask

    task automatic test_drain_wrap();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.out_ready_i = 1'b1;
            #1;
            checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d]: got %b want 1", i, bus.out_valid_o); end
            checks++; if (bus.out_data_o !== 8'h11 + 8'(i)) begin errors++; $display("FAIL drain_data[%0d]: got %h want %h", i, bus.out_data_o, 8'h11 + 8'(i)); end
            checks++; if (count !== 3'(5 - i)) begin errors++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, count, 5 - i); end
        end
        @(negedge clk);
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drained_empty: got %b want 1", empty); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL drained_count: got %0d want 0", count); end
        checks++; if (bus.out_data_o !== 8'h00) begin errors++; $display("FAIL drained_data: got %h want 00", bus.out_data_o); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.in_valid_i = (i < 3);
            bus.in_data_i  = 8'h21 + 8'(i);
            #1;
            if (i == 0) begin
                checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL stream_latency: got %b want 0", bus.out_valid_o); end
            end else begin
                checks++; if (bus.out_data_o !== 8'h20 + 8'(i)) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", i, bus.out_data_o, 8'h20 + 8'(i)); end
                checks++; if (count !== 3'd1) begin errors++; $display("FAIL stream_count[%0d]: got %0d want 1", i, count); end
            end
        end
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL stream_empty: got %b want 1", empty); end
        bus.out_ready_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q [5] = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h66};
        fill_dut(8'h11);
        bus.in_valid_i  = 1'b1;
        bus.in_data_i   = 8'h66;
        bus.out_ready_i = 1'b1;
        #1;
        checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b want 1", bus.in_ready_o); end
        checks++; if (bus.out_data_o !== 8'h11) begin errors++; $display("FAIL b2b_out_data: got %h want 11", bus.out_data_o); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid_i = 1'b0;
            #1;
            checks++; if (bus.out_data_o !== exp_q[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, bus.out_data_o, exp_q[i]); end
            checks++; if (count !== 3'(5 - i)) begin errors++; $display("FAIL b2b_count[%0d]: got %0d want %0d", i, count, 5 - i); end
        end
        @(negedge clk);
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b want 1", empty); end
        bus.out_ready_i = 1'b0;
    endtask

    task automatic test_overwrite();
        logic [7:0] exp_q [5] = '{8'h12, 8'h13, 8'h14, 8'h15, 8'hAA};
        fill_ow(8'h11);
        bus_ow.in_valid_i = 1'b1;
        bus_ow.in_data_i  = 8'hAA;
        #1;
        checks++; if (bus_ow.in_ready_o !== 1'b1) begin errors++; $display("FAIL ow_in_ready: got %b want 1", bus_ow.in_ready_o); end
        checks++; if (drop_ow !== 1'b1) begin errors++; $display("FAIL ow_drop_pulse: got %b want 1", drop_ow); end
        @(negedge clk);
        bus_ow.in_valid_i = 1'b0;
        #1;
        checks++; if (drop_ow !== 1'b0) begin errors++; $display("FAIL ow_drop_end: got %b want 0", drop_ow); end
        checks++; if (drop_cnt_ow !== 16'd1) begin errors++; $display("FAIL ow_drop_cnt: got %0d want 1", drop_cnt_ow); end
        checks++; if (count_ow !== 3'd5) begin errors++; $display("FAIL ow_count: got %0d want 5", count_ow); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus_ow.out_ready_i = 1'b1;
            #1;
            checks++; if (bus_ow.out_data_o !== exp_q[i]) begin errors++; $display("FAIL ow_data[%0d]: got %h want %h", i, bus_ow.out_data_o, exp_q[i]); end
        end
        @(negedge clk);
        #1;
        checks++; if (empty_ow !== 1'b1) begin errors++; $display("FAIL ow_empty: got %b want 1", empty_ow); end
        bus_ow.out_ready_i = 1'b0;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_ow.in_valid_i = 1'b1;
            bus_ow.in_data_i  = 8'h31 + 8'(i);
        end
        @(negedge clk);
        flush_ow         = 1'b1;
        bus_ow.in_data_i = 8'h77;
        #1;
        checks++; if (bus_ow.in_ready_o !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", bus_ow.in_ready_o); end
        checks++; if (bus_ow.out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b want 0", bus_ow.out_valid_o); end
        checks++; if (count_ow !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d want 3", count_ow); end
        @(negedge clk);
        flush_ow          = 1'b0;
        bus_ow.in_valid_i = 1'b0;
        #1;
        checks++; if (count_ow !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", count_ow); end
        checks++; if (empty_ow !== 1'b1) begin errors++; $display("FAIL flush_empty: got %b want 1", empty_ow); end
        checks++; if (ae_ow !== 1'b1) begin errors++; $display("FAIL flush_ae: got %b want 1", ae_ow); end
        checks++; if (drop_cnt_ow !== 16'd1) begin errors++; $display("FAIL flush_drop_cnt: got %0d want 1", drop_cnt_ow); end
        bus_ow.in_valid_i = 1'b1;
        bus_ow.in_data_i  = 8'h41;
        @(negedge clk);
        bus_ow.in_valid_i = 1'b0;
        #1;
        checks++; if (bus_ow.out_data_o !== 8'h41) begin errors++; $display("FAIL post_flush_data: got %h want 41", bus_ow.out_data_o); end
        bus_ow.out_ready_i = 1'b1;
        @(negedge clk);
        bus_ow.out_ready_i = 1'b0;
    endtask

    task automatic test_async_reset();
        fill_ow(8'h51);
        bus_ow.in_valid_i = 1'b1;
        bus_ow.in_data_i  = 8'hBB;
        @(negedge clk);
        bus_ow.in_valid_i  = 1'b0;
        bus_ow.out_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus_ow.out_ready_i = 1'b0;
        #1;
        checks++; if (count_ow !== 3'd3) begin errors++; $display("FAIL pre_rst_count: got %0d want 3", count_ow); end
        checks++; if (drop_cnt_ow !== 16'd2) begin errors++; $display("FAIL pre_rst_drop_cnt: got %0d want 2", drop_cnt_ow); end
        rstn = 1'b0;
        #1;
        checks++; if (count_ow !== 3'd0) begin errors++; $display("FAIL arst_count: got %0d want 0", count_ow); end
        checks++; if (drop_cnt_ow !== 16'd0) begin errors++; $display("FAIL arst_drop_cnt: got %0d want 0", drop_cnt_ow); end
        checks++; if (bus_ow.out_valid_o !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %b want 0", bus_ow.out_valid_o); end
        checks++; if (bus_ow.out_data_o !== 8'h00) begin errors++; $display("FAIL arst_out_data: got %h want 00", bus_ow.out_data_o); end
        checks++; if (empty_ow !== 1'b1) begin errors++; $display("FAIL arst_empty: got %b want 1", empty_ow); end
        checks++; if (bus_ow.in_ready_o !== 1'b1) begin errors++; $display("FAIL arst_in_ready: got %b want 1", bus_ow.in_ready_o); end
        @(negedge clk);
        @(negedge clk);
        rstn              = 1'b1;
        bus_ow.in_valid_i = 1'b1;
        bus_ow.in_data_i  = 8'h5A;
        @(negedge clk);
        bus_ow.in_valid_i = 1'b0;
        #1;
        checks++; if (bus_ow.out_data_o !== 8'h5A) begin errors++; $display("FAIL post_rst_data: got %h want 5a", bus_ow.out_data_o); end
        checks++; if (count_ow !== 3'd1) begin errors++; $display("FAIL post_rst_count: got %0d want 1", count_ow); end
    endtask

    initial begin
        rstn               = 1'b0;
        flush              = 1'b0;
        flush_ow           = 1'b0;
        bus.in_valid_i     = 1'b0;
        bus.in_data_i      = 8'h00;
        bus.out_ready_i    = 1'b0;
        bus_ow.in_valid_i  = 1'b0;
        bus_ow.in_data_i   = 8'h00;
        bus_ow.out_ready_i = 1'b0;
        test_reset();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        test_fill();
        test_drain_wrap();
        test_back_to_back();
        test_overwrite();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
